// File: rtl/spi_eeprom_slave.sv
// ---------------------------------------------------------------------------
// spi_eeprom_slave
//
// SPI mode-0 responder that behaves like a 128 x 8 serial EEPROM
// (M25AA010A command subset: READ, WRITE, WREN, WRDI, RDSR, WRSR).
// The SPI pins are oversampled in the clk_50M domain. Writes land in a page
// buffer and are copied into the array during a modelled write-cycle
// busy time.
//
// Ports
//   clk_50M     : sole clock, rising edge
//   reset       : synchronous, active-low reset
//   spi_sck     : SPI clock from the master (asynchronous)
//   spi_csn     : SPI chip select, active low (asynchronous)
//   spi_si      : serial data from the master
//   spi_so      : serial data to the master (0 when not driven)
//   spi_so_oe   : high while spi_so is driven (RD_OUT / STAT_OUT, csn low)
//   cmd_done    : one-cycle pulse at the end of every transaction
//   cmd_opcode  : opcode of the last completed transaction
//   status      : {4'b0, BP1, BP0, WEL, WIP}
//   dbg_state_o : current FSM state, for observation only
//
// Bus handshake: there is no valid/ready pair. A transaction is framed by
// spi_csn low; bits are sampled on rising sck and driven on falling sck.
// ---------------------------------------------------------------------------
module spi_eeprom_slave #(
    parameter int ADDR_W     = 7,
    parameter int PAGE_SIZE  = 16,
    parameter int TWC_CYCLES = 250000
) (
    input  logic       clk_50M,
    input  logic       reset,
    input  logic       spi_sck,
    input  logic       spi_csn,
    input  logic       spi_si,
    output logic       spi_so,
    output logic       spi_so_oe,
    output logic       cmd_done,
    output logic [7:0] cmd_opcode,
    output logic [7:0] status,
    output logic [3:0] dbg_state_o
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int PG_W  = $clog2(PAGE_SIZE);
    localparam int CI_W  = PG_W + 1;
    localparam int CNT_W = $clog2(TWC_CYCLES + 1);

    localparam logic [7:0] OP_WRSR = 8'h01;
    localparam logic [7:0] OP_WRITE = 8'h02;
    localparam logic [7:0] OP_READ = 8'h03;
    localparam logic [7:0] OP_WRDI = 8'h04;
    localparam logic [7:0] OP_RDSR = 8'h05;
    localparam logic [7:0] OP_WREN = 8'h06;

    typedef enum logic [3:0] {
        S_IDLE,
        S_OPCODE,
        S_ADDR,
        S_RD_OUT,
        S_STAT_OUT,
        S_WR_IN,
        S_SR_IN,
        S_WAIT_CS,
        S_IGNORE
    } state_e;

    state_e state_q, state_d;

    // Synchronizers: [0] first flop, [1] synced value, [2] previous synced value
    logic [2:0] sck_sync_q;
    logic [2:0] csn_sync_q;
    logic [1:0] si_sync_q;

    logic [2:0]        bit_cnt_q;
    logic [6:0]        rx_shift_q;
    logic [7:0]        opcode_q;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        tx_q;
    logic              so_q;
    logic              cmd_done_q;
    logic [7:0]        cmd_opcode_q;
    logic [1:0]        bp_q;
    logic              wel_q;
    logic              wip_q;
    logic [CNT_W-1:0]  wip_cnt_q;
    logic [CI_W-1:0]   copy_idx_q;
    logic [PAGE_SIZE-1:0] pg_valid_q;
    logic              have_data_q;
    logic [1:0]        sr_stage_q;
    logic              sr_staged_q;

    logic [7:0] page_buf_q [PAGE_SIZE];
    logic [7:0] mem_q [DEPTH] = '{default: 8'hFF};

    logic              csn_high, csn_rise, sck_rise, sck_fall, byte_done, commit_ok;
    logic [7:0]        new_byte;
    logic [7:0]        status_w;
    logic [ADDR_W-1:0] addr_inc;
    logic [PG_W-1:0]   pg_idx;
    logic              copy_en;
    logic [ADDR_W-1:0] copy_addr;

    // Top two address bits are enough to decide block protection.
    function automatic logic is_protected(input logic [1:0] bp, input logic [1:0] a_top);
        case (bp)
            2'b01:   return &a_top;
            2'b10:   return a_top[1];
            2'b11:   return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    assign csn_high  = csn_sync_q[1];
    assign csn_rise  = csn_sync_q[1] & ~csn_sync_q[2];
    // sck edges are only meaningful while selected; a csn rise always wins.
    assign sck_rise  = sck_sync_q[1] & ~sck_sync_q[2] & ~csn_high;
    assign sck_fall  = ~sck_sync_q[1] & sck_sync_q[2] & ~csn_high;
    assign new_byte  = {rx_shift_q, si_sync_q[1]};
    assign byte_done = sck_rise && (bit_cnt_q == 3'd7);
    assign commit_ok = csn_rise && (bit_cnt_q == 3'd0);
    assign status_w  = {4'b0000, bp_q, wel_q, wip_q};
    assign addr_inc  = addr_q + ADDR_W'(1);
    assign pg_idx    = addr_q[PG_W-1:0];

    // The page number stays in addr_q during WIP because only RDSR can run then.
    assign copy_en   = reset && wip_q && (copy_idx_q < CI_W'(PAGE_SIZE));
    assign copy_addr = {addr_q[ADDR_W-1:PG_W], copy_idx_q[PG_W-1:0]};

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        if (csn_rise) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (!csn_high) state_d = S_OPCODE;
                end
                S_OPCODE: begin
                    if (byte_done) begin
                        if (wip_q && new_byte != OP_RDSR) begin
                            state_d = S_IGNORE;
                        end else begin
                            case (new_byte)
                                OP_READ, OP_WRITE: state_d = S_ADDR;
                                OP_RDSR:           state_d = S_STAT_OUT;
                                OP_WRSR:           state_d = S_SR_IN;
                                OP_WREN, OP_WRDI:  state_d = S_WAIT_CS;
                                default:           state_d = S_IGNORE;
                            endcase
                        end
                    end
                end
                S_ADDR: begin
                    if (byte_done) state_d = (opcode_q == OP_READ) ? S_RD_OUT : S_WR_IN;
                end
                default: ;
            endcase
        end
    end

    // ---------------- control / datapath registers ----------------
    always_ff @(posedge clk_50M) begin
        if (!reset) begin
            sck_sync_q   <= 3'b000;
            csn_sync_q   <= 3'b111;
            si_sync_q    <= 2'b00;
            state_q      <= S_IDLE;
            bit_cnt_q    <= 3'd0;
            rx_shift_q   <= 7'd0;
            opcode_q     <= 8'h00;
            addr_q       <= '0;
            tx_q         <= 8'h00;
            so_q         <= 1'b0;
            cmd_done_q   <= 1'b0;
            cmd_opcode_q <= 8'h00;
            bp_q         <= 2'b00;
            wel_q        <= 1'b0;
            wip_q        <= 1'b0;
            wip_cnt_q    <= '0;
            copy_idx_q   <= CI_W'(PAGE_SIZE);
            pg_valid_q   <= '0;
            have_data_q  <= 1'b0;
            sr_stage_q   <= 2'b00;
            sr_staged_q  <= 1'b0;
        end else begin
            sck_sync_q <= {sck_sync_q[1:0], spi_sck};
            csn_sync_q <= {csn_sync_q[1:0], spi_csn};
            si_sync_q  <= {si_sync_q[0], spi_si};
            state_q    <= state_d;
            cmd_done_q <= csn_rise;

            if (csn_high) begin
                bit_cnt_q <= 3'd0;
                so_q      <= 1'b0;
            end else begin
                if (sck_rise) begin
                    rx_shift_q <= new_byte[6:0];
                    bit_cnt_q  <= bit_cnt_q + 3'd1;
                end
                if (sck_fall) begin
                    so_q <= tx_q[7];
                    tx_q <= {tx_q[6:0], 1'b0};
                end
            end

            if (state_q == S_IDLE) begin
                opcode_q    <= 8'h00;
                have_data_q <= 1'b0;
                sr_staged_q <= 1'b0;
            end

            if (byte_done) begin
                case (state_q)
                    S_OPCODE: begin
                        opcode_q <= new_byte;
                        if (state_d == S_STAT_OUT) tx_q <= status_w;
                    end
                    S_ADDR: begin
                        addr_q <= new_byte[ADDR_W-1:0];
                        if (opcode_q == OP_READ) tx_q <= mem_q[new_byte[ADDR_W-1:0]];
                        else                     pg_valid_q <= '0;
                    end
                    S_RD_OUT: begin
                        addr_q <= addr_inc;
                        tx_q   <= mem_q[addr_inc];
                    end
                    S_STAT_OUT: tx_q <= status_w;
                    S_WR_IN: begin
                        pg_valid_q[pg_idx]  <= 1'b1;
                        addr_q[PG_W-1:0]    <= pg_idx + PG_W'(1);
                        have_data_q         <= 1'b1;
                    end
                    S_SR_IN: begin
                        if (!sr_staged_q) begin
                            sr_stage_q  <= new_byte[3:2];
                            sr_staged_q <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end

            if (csn_rise) cmd_opcode_q <= opcode_q;

            if (copy_en) copy_idx_q <= copy_idx_q + CI_W'(1);

            if (wip_q) begin
                if (wip_cnt_q == '0) wip_q <= 1'b0;
                else                 wip_cnt_q <= wip_cnt_q - CNT_W'(1);
            end else if (commit_ok) begin
                case (state_q)
                    S_WAIT_CS: begin
                        if (opcode_q == OP_WREN)      wel_q <= 1'b1;
                        else if (opcode_q == OP_WRDI) wel_q <= 1'b0;
                    end
                    S_SR_IN: begin
                        if (wel_q && sr_staged_q) begin
                            bp_q      <= sr_stage_q;
                            wip_q     <= 1'b1;
                            wel_q     <= 1'b0;
                            wip_cnt_q <= CNT_W'(TWC_CYCLES);
                        end
                    end
                    S_WR_IN: begin
                        if (wel_q && have_data_q) begin
                            wip_q      <= 1'b1;
                            wel_q      <= 1'b0;
                            wip_cnt_q  <= CNT_W'(TWC_CYCLES);
                            copy_idx_q <= '0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Page buffer: data only, validity is tracked in pg_valid_q.
    always_ff @(posedge clk_50M) begin
        if (reset && byte_done && state_q == S_WR_IN) page_buf_q[pg_idx] <= new_byte;
    end

    // Array update: one page entry per cycle at the start of the write cycle.
    always_ff @(posedge clk_50M) begin
        if (copy_en && pg_valid_q[copy_idx_q[PG_W-1:0]] &&
            !is_protected(bp_q, copy_addr[ADDR_W-1 -: 2])) begin
            mem_q[copy_addr] <= page_buf_q[copy_idx_q[PG_W-1:0]];
        end
    end

    assign spi_so_oe   = (state_q == S_RD_OUT || state_q == S_STAT_OUT) && !csn_high;
    assign spi_so      = spi_so_oe & so_q;
    assign cmd_done    = cmd_done_q;
    assign cmd_opcode  = cmd_opcode_q;
    assign status      = status_w;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_spi_eeprom_slave.sv
// ---------------------------------------------------------------------------
// tb_spi_eeprom_slave
//
// Drives SPI mode-0 transactions into spi_eeprom_slave and compares read
// data, status and command reporting with a transaction-level EEPROM model
// (byte array + WEL/BP flags).
// ---------------------------------------------------------------------------
module tb_spi_eeprom_slave;

    localparam int TWC  = 800;
    localparam int HALF = 8;

    // ---------------- clock / reset ----------------
    logic       clk_50M = 1'b0;
    logic       reset   = 1'b0;
    logic       spi_sck = 1'b0;
    logic       spi_csn = 1'b1;
    logic       spi_si  = 1'b0;
    logic       spi_so, spi_so_oe, cmd_done;
    logic [7:0] cmd_opcode, status;
    logic [3:0] dbg_state;

    always #10 clk_50M = ~clk_50M;

    spi_eeprom_slave #(
        .ADDR_W(7), .PAGE_SIZE(16), .TWC_CYCLES(TWC)
    ) dut (
        .clk_50M(clk_50M), .reset(reset),
        .spi_sck(spi_sck), .spi_csn(spi_csn), .spi_si(spi_si),
        .spi_so(spi_so), .spi_so_oe(spi_so_oe),
        .cmd_done(cmd_done), .cmd_opcode(cmd_opcode), .status(status),
        .dbg_state_o(dbg_state)
    );

    // ---------------- bookkeeping / model state ----------------
    int n_cmp = 0;
    int n_mis = 0;

    logic [7:0] m_mem [128];
    logic       m_wel;
    logic [1:0] m_bp;

    logic [7:0] txb[$];
    logic [7:0] rxb[$];
    logic [7:0] wdat[$];
    logic [7:0] exp_q[$];
    logic       oe_seen;
    logic [7:0] st_done, op_done;

    function automatic logic m_prot(input int a);
        case (m_bp)
            2'd1:    return a >= 8'h60;
            2'd2:    return a >= 8'h40;
            2'd3:    return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [7:0] m_status();
        return {4'b0000, m_bp, m_wel, 1'b0};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk_50M);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic xfer_bit(input logic b, output logic r);
        spi_si = b;
        tick(HALF);
        r = spi_so;
        if (spi_so_oe) oe_seen = 1'b1;
        spi_sck = 1'b1;
        tick(HALF);
        spi_sck = 1'b0;
    endtask

    // Sends txb, then 'partial' extra bits, raises csn and waits for cmd_done.
    task automatic run_txn(input int partial);
        logic [7:0] rb;
        logic       r;
        logic       got;
        rxb.delete();
        oe_seen = 1'b0;
        spi_csn = 1'b0;
        tick(HALF);
        foreach (txb[i]) begin
            for (int k = 7; k >= 0; k--) begin
                xfer_bit(txb[i][k], r);
                rb[k] = r;
            end
            rxb.push_back(rb);
        end
        for (int k = 0; k < partial; k++) xfer_bit(1'b1, r);
        tick(HALF);
        spi_csn = 1'b1;
        got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            tick(1);
            if (cmd_done === 1'b1) begin
                got     = 1'b1;
                st_done = status;
                op_done = cmd_opcode;
            end
        end
        check("cmd_done_pulse", 32'(got), 32'd1);
        tick(4);
    endtask

    task automatic wait_idle();
        logic ok;
        ok = 1'b0;
        for (int c = 0; c < 3 * TWC && !ok; c++) begin
            tick(1);
            if (status[0] === 1'b0) ok = 1'b1;
        end
        check("wip_clears", 32'(ok), 32'd1);
    endtask

    task automatic do_wren();
        txb = {8'h06};
        run_txn(0);
        m_wel = 1'b1;
        check("wren_opcode", 32'(op_done), 32'h06);
    endtask

    task automatic do_wrsr(input logic [7:0] val);
        do_wren();
        txb = {8'h01, val};
        run_txn(0);
        m_bp  = val[3:2];
        m_wel = 1'b0;
        check("wrsr_status_at_done", 32'(st_done), 32'(m_status() | 8'h01));
        wait_idle();
        check("wrsr_status", 32'(status), 32'(m_status()));
    endtask

    // Writes wdat starting at addr; applies the page-buffer rules to the model.
    task automatic do_write(input logic [7:0] addr, input logic with_wren, input logic wait_done);
        logic [7:0] pb [16];
        logic       pv [16];
        logic       committed;
        int         base;
        if (with_wren) do_wren();
        txb = {8'h02, addr};
        foreach (wdat[i]) txb.push_back(wdat[i]);
        run_txn(0);
        check("write_opcode", 32'(op_done), 32'h02);
        committed = m_wel && (wdat.size() > 0);
        if (committed) begin
            for (int j = 0; j < 16; j++) pv[j] = 1'b0;
            foreach (wdat[i]) begin
                pb[(int'(addr[3:0]) + i) % 16] = wdat[i];
                pv[(int'(addr[3:0]) + i) % 16] = 1'b1;
            end
            base = int'(addr[6:4]) * 16;
            for (int j = 0; j < 16; j++)
                if (pv[j] && !m_prot(base + j)) m_mem[base + j] = pb[j];
            m_wel = 1'b0;
        end
        check("write_wip_at_done", 32'(st_done[0]), 32'(committed));
        if (wait_done) begin
            wait_idle();
            check("write_status", 32'(status), 32'(m_status()));
        end
    endtask

    task automatic do_read(input logic [7:0] addr, input int n);
        txb = {8'h03, addr};
        for (int i = 0; i < n; i++) txb.push_back(8'h00);
        run_txn(0);
        for (int i = 0; i < n; i++) exp_q.push_back(m_mem[(int'(addr[6:0]) + i) % 128]);
        for (int i = 0; i < n; i++) check("read_data", 32'(rxb[2 + i]), 32'(exp_q.pop_front()));
        check("read_oe", 32'(oe_seen), 32'd1);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        logic [7:0] a;
        int         n;

        for (int i = 0; i < 128; i++) m_mem[i] = 8'hFF;
        m_wel = 1'b0;
        m_bp  = 2'b00;

        // reset state
        tick(5);
        check("rst_status", 32'(status), 32'h00);
        check("rst_so", 32'(spi_so), 32'd0);
        check("rst_so_oe", 32'(spi_so_oe), 32'd0);
        check("rst_cmd_done", 32'(cmd_done), 32'd0);
        check("rst_cmd_opcode", 32'(cmd_opcode), 32'h00);
        reset = 1'b1;
        tick(5);

        // WREN then RDSR
        do_wren();
        check("wren_status", 32'(status), 32'h02);
        txb = {8'h05, 8'h00};
        run_txn(0);
        check("rdsr_shift", 32'(rxb[1]), 32'h02);
        check("rdsr_oe", 32'(oe_seen), 32'd1);
        check("rdsr_opcode", 32'(op_done), 32'h05);

        // two-byte write and readback
        wdat = {8'hA5, 8'h5A};
        do_write(8'h10, 1'b1, 1'b1);
        do_read(8'h10, 2);

        // page wrap
        wdat = {8'h01, 8'h02, 8'h03, 8'h04};
        do_write(8'h1E, 1'b1, 1'b1);
        do_read(8'h1E, 2);
        do_read(8'h10, 2);

        // address wrap on read (address MSB ignored)
        do_read(8'hFF, 2);

        // write without WREN
        wdat = {8'hC3};
        do_write(8'h50, 1'b0, 1'b1);
        do_read(8'h50, 1);

        // block protection
        do_wrsr(8'h04);
        wdat = {8'h00};
        do_write(8'h60, 1'b1, 1'b1);
        do_read(8'h60, 1);
        do_write(8'h20, 1'b1, 1'b1);
        do_read(8'h20, 1);

        // partial-byte abort
        do_wren();
        txb = {8'h02, 8'h30, 8'h99};
        run_txn(5);
        check("abort_no_wip", 32'(st_done[0]), 32'd0);
        check("abort_status", 32'(status), 32'(m_status()));
        do_read(8'h30, 1);
        txb = {8'h04};
        run_txn(0);
        m_wel = 1'b0;
        check("wrdi_status", 32'(status), 32'(m_status()));

        // commands other than RDSR are ignored during WIP
        wdat = {8'h77};
        do_write(8'h40, 1'b1, 1'b0);
        txb = {8'h06};
        run_txn(0);
        txb = {8'h03, 8'h40, 8'h00};
        run_txn(0);
        check("wip_read_no_oe", 32'(oe_seen), 32'd0);
        check("wip_read_data", 32'(rxb[2]), 32'h00);
        wait_idle();
        check("wip_wren_ignored", 32'(status), 32'(m_status()));
        do_read(8'h40, 1);

        // randomized writes against the model
        for (int it = 0; it < 5; it++) begin
            do_wrsr({4'b0000, 2'($urandom_range(0, 3)), 2'b00});
            a = 8'($urandom_range(0, 255));
            n = $urandom_range(1, 20);
            wdat.delete();
            for (int i = 0; i < n; i++) wdat.push_back(8'($urandom_range(0, 255)));
            do_write(a, 1'b1, 1'b1);
            do_read({1'b0, a[6:4], 4'h0}, 16);
        end

        // reset during a write cycle
        do_wrsr(8'h00);
        wdat = {8'h11};
        do_write(8'h05, 1'b1, 1'b0);
        reset = 1'b0;
        tick(1);
        check("rst_wip_status", 32'(status), 32'h00);
        check("rst_wip_oe", 32'(spi_so_oe), 32'd0);
        reset = 1'b1;
        tick(5);
        txb = {8'h05, 8'h00};
        run_txn(0);
        check("rst_rdsr_shift", 32'(rxb[1]), 32'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
